// File: rtl/electra_conduit_export_ctrl.sv
// Electra conduit export controller: NUM_CH HPS-programmable output channels with
// direct, atomic-commit and timed-pulse modes, programmed over an Avalon-MM slave.
module electra_conduit_export_ctrl #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_WIDTH = 32,
  parameter int unsigned PULSE_W  = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_CH*4+1)
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [ADDR_W-1:0]            avs_address,
  input  logic                         avs_write,
  input  logic [31:0]                  avs_writedata,
  input  logic                         avs_read,
  output logic [31:0]                  avs_readdata,
  output logic                         avs_readdatavalid,
  output logic [NUM_CH*CH_WIDTH-1:0]   conduit_export,
  output logic [NUM_CH-1:0]            update_strobe
);

  localparam logic [1:0]        MODE_COMMIT = 2'd1;
  localparam logic [1:0]        MODE_PULSE  = 2'd2;
  localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(4*NUM_CH);

  logic [NUM_CH-1:0][CH_WIDTH-1:0] shadow_w;
  logic [NUM_CH-1:0][CH_WIDTH-1:0] out_w;
  logic [NUM_CH-1:0][1:0]          mode_w;
  logic [NUM_CH-1:0][PULSE_W-1:0]  plen_w;
  logic [NUM_CH-1:0]               active_w;
  logic [NUM_CH-1:0]               pending_w;
  logic                            commit_wr;
  logic [31:0]                     rdata_c;

  assign commit_wr      = avs_write && (avs_address == COMMIT_ADDR);
  assign conduit_export = out_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_SHADOW = ADDR_W'(4*i);
    localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(4*i+1);
    localparam logic [ADDR_W-1:0] A_PLEN   = ADDR_W'(4*i+2);

    logic [CH_WIDTH-1:0] shadow_q;
    logic [CH_WIDTH-1:0] out_q;
    logic [1:0]          mode_q;
    logic [PULSE_W-1:0]  plen_q;
    logic [PULSE_W-1:0]  cnt_q;
    logic [PULSE_W-1:0]  load_c;
    logic                active_q;
    logic                pending_q;
    logic                strobe_q;
    logic                wr_shadow;
    logic                wr_mode;
    logic                wr_plen;
    logic                commit_hit;

    assign wr_shadow  = avs_write && (avs_address == A_SHADOW);
    assign wr_mode    = avs_write && (avs_address == A_MODE);
    assign wr_plen    = avs_write && (avs_address == A_PLEN);
    assign commit_hit = commit_wr && avs_writedata[i] && (mode_q == MODE_COMMIT) && pending_q;
    // A zero pulse length still produces a one-cycle pulse
    assign load_c     = (plen_q == '0) ? PULSE_W'(1) : plen_q;

    // Channel state: a shadow write, mode write or commit pre-empts the pulse countdown
    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        shadow_q  <= '0;
        out_q     <= '0;
        mode_q    <= '0;
        plen_q    <= PULSE_W'(1);
        cnt_q     <= '0;
        active_q  <= 1'b0;
        pending_q <= 1'b0;
        strobe_q  <= 1'b0;
      end else begin
        strobe_q <= 1'b0;
        if (wr_shadow) begin
          shadow_q <= avs_writedata[CH_WIDTH-1:0];
          if (mode_q == MODE_COMMIT) begin
            pending_q <= 1'b1;
          end else begin
            out_q    <= avs_writedata[CH_WIDTH-1:0];
            strobe_q <= 1'b1;
            if (mode_q == MODE_PULSE) begin
              cnt_q    <= load_c;
              active_q <= 1'b1;
            end
          end
        end else if (wr_mode) begin
          mode_q    <= avs_writedata[1:0];
          pending_q <= 1'b0;
          if (active_q) begin
            out_q    <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
          end
        end else if (commit_hit) begin
          out_q     <= shadow_q;
          pending_q <= 1'b0;
          strobe_q  <= 1'b1;
        end else if (active_q) begin
          if (cnt_q == PULSE_W'(1)) begin
            out_q    <= '0;
            active_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q - PULSE_W'(1);
          end
        end
        if (wr_plen) plen_q <= avs_writedata[PULSE_W-1:0];
      end
    end

    assign shadow_w[i]      = shadow_q;
    assign out_w[i]         = out_q;
    assign mode_w[i]        = mode_q;
    assign plen_w[i]        = plen_q;
    assign active_w[i]      = active_q;
    assign pending_w[i]     = pending_q;
    assign update_strobe[i] = strobe_q;
  end

  // Read decode from pre-edge state; unmapped locations return zero
  always_comb begin
    rdata_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (avs_address == ADDR_W'(4*i))   rdata_c = 32'(shadow_w[i]);
      if (avs_address == ADDR_W'(4*i+1)) rdata_c = 32'(mode_w[i]);
      if (avs_address == ADDR_W'(4*i+2)) rdata_c = 32'(plen_w[i]);
      if (avs_address == ADDR_W'(4*i+3)) rdata_c = 32'({pending_w[i], active_w[i]});
    end
    if (avs_address == COMMIT_ADDR) rdata_c = 32'(pending_w);
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rdata_c;
    end
  end

endmodule

// File: tb/tb_electra_conduit_export_ctrl.sv
// Bench for electra_conduit_export_ctrl: directed vector table, hand-written pulse,
// abort and reset sequences, then random traffic against a time-based channel model.
module tb_electra_conduit_export_ctrl;

  localparam logic [127:0] EZ = '0;
  localparam logic [127:0] E0 = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
  localparam logic [127:0] E1 = {32'h0, 32'h22, 32'h11, 32'hDEADBEEF};
  localparam logic [127:0] E2 = {32'h0, 32'h22, 32'h11, 32'h12345678};

  logic         clk;
  logic         rst;
  logic [4:0]   addr;
  logic         wr;
  logic [31:0]  wdata;
  logic         rd;
  logic [31:0]  rdata;
  logic         rvalid;
  logic [127:0] cexp;
  logic [3:0]   stb;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pulses tracked by the edge number at which they end
  logic [31:0] m_shadow [4];
  logic [1:0]  m_mode   [4];
  logic [15:0] m_plen   [4];
  logic [31:0] m_out    [4];
  logic        m_pend   [4];
  logic        m_act    [4];
  int          m_end    [4];
  logic [3:0]  m_stb;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  int          t;

  typedef struct {
    logic         w;
    logic         r;
    logic [4:0]   a;
    logic [31:0]  d;
    logic [127:0] e;
    logic [3:0]   s;
    logic [31:0]  er;
  } vec_t;

  vec_t tbl[$];

  electra_conduit_export_ctrl dut (
    .clk_clk           (clk),
    .reset_reset       (rst),
    .avs_address       (addr),
    .avs_write         (wr),
    .avs_writedata     (wdata),
    .avs_read          (rd),
    .avs_readdata      (rdata),
    .avs_readdatavalid (rvalid),
    .conduit_export    (cexp),
    .update_strobe     (stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int w, int r, int a, logic [31:0] d, logic [127:0] e, int s,
                              logic [31:0] er);
    vec_t v;
    v.w = 1'(w); v.r = 1'(r); v.a = 5'(a); v.d = d; v.e = e; v.s = 4'(s); v.er = er;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = '0; m_mode[i] = '0; m_plen[i] = 16'd1; m_out[i] = '0;
      m_pend[i] = 1'b0; m_act[i] = 1'b0; m_end[i] = 0;
    end
    m_stb = '0; m_rvalid = 1'b0; m_rdata = '0; t = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int ch;
    ch = int'(a) / 4;
    if (a < 5'd16) begin
      case (int'(a) % 4)
        0:       return m_shadow[ch];
        1:       return 32'(m_mode[ch]);
        2:       return 32'(m_plen[ch]);
        default: return 32'({m_pend[ch], m_act[ch]});
      endcase
    end
    if (a == 5'd16) return {28'h0, m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
    return '0;
  endfunction

  task automatic model_edge(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d);
    int len;
    t++;
    m_rvalid = r;
    if (r) m_rdata = model_read(a);
    m_stb = '0;
    for (int i = 0; i < 4; i++) begin
      len = (m_plen[i] == 16'd0) ? 1 : int'(m_plen[i]);
      if (w && a == 5'(4*i)) begin
        m_shadow[i] = d;
        if (m_mode[i] == 2'd1) m_pend[i] = 1'b1;
        else begin
          m_out[i] = d;
          m_stb[i] = 1'b1;
          if (m_mode[i] == 2'd2) begin
            m_act[i] = 1'b1;
            m_end[i] = t + len;
          end
        end
      end else if (w && a == 5'(4*i+1)) begin
        m_mode[i] = d[1:0];
        m_pend[i] = 1'b0;
        if (m_act[i]) begin
          m_out[i] = '0;
          m_act[i] = 1'b0;
        end
      end else if (w && a == 5'd16 && d[i] && m_mode[i] == 2'd1 && m_pend[i]) begin
        m_out[i]  = m_shadow[i];
        m_pend[i] = 1'b0;
        m_stb[i]  = 1'b1;
      end else if (m_act[i] && t == m_end[i]) begin
        m_out[i] = '0;
        m_act[i] = 1'b0;
      end
      if (w && a == 5'(4*i+2)) m_plen[i] = d[15:0];
    end
  endtask

  // One clock: drive, let the edge happen, update the model, compare 1ns later
  task automatic step(input logic w, input logic r, input logic [4:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk);
    model_edge(w, r, a, d);
    #1;
    wr = 1'b0; rd = 1'b0;
    check("model export", cexp, {m_out[3], m_out[2], m_out[1], m_out[0]});
    check("model strobe", 128'(stb), 128'(m_stb));
    check("model rvalid", 128'(rvalid), 128'(m_rvalid));
    if (m_rvalid) check("model rdata", 128'(rdata), 128'(m_rdata));
  endtask

  task automatic chk3(input string n, input logic [31:0] v, input logic s);
    check({n, " ch3"}, 128'(cexp[127:96]), 128'(v));
    check({n, " stb3"}, 128'(stb[3]), 128'(s));
  endtask

  task automatic chk_read(input string n, input logic [4:0] a, input logic [31:0] exp);
    step(1'b0, 1'b1, a, 32'h0);
    check(n, 128'(rdata), 128'(exp));
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rdv;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    model_reset();
    #22;
    check("reset export", cexp, EZ);
    check("reset strobe", 128'(stb), 128'(0));
    check("reset rvalid", 128'(rvalid), 128'(0));
    check("reset rdata", 128'(rdata), 128'(0));
    rst = 1'b0;

    // Directed register/commit/decode vectors
    tbl.push_back(mk(0, 1, 2,  0,           EZ, 0, 1));
    tbl.push_back(mk(0, 1, 0,  0,           EZ, 0, 0));
    tbl.push_back(mk(0, 1, 16, 0,           EZ, 0, 0));
    tbl.push_back(mk(0, 1, 17, 0,           EZ, 0, 0));
    tbl.push_back(mk(0, 1, 15, 0,           EZ, 0, 0));
    tbl.push_back(mk(1, 0, 0,  'hDEADBEEF,  E0, 1, 0));
    tbl.push_back(mk(0, 0, 0,  0,           E0, 0, 0));
    tbl.push_back(mk(1, 0, 5,  1,           E0, 0, 0));
    tbl.push_back(mk(1, 0, 9,  1,           E0, 0, 0));
    tbl.push_back(mk(1, 0, 4,  'h11,        E0, 0, 0));
    tbl.push_back(mk(1, 0, 8,  'h22,        E0, 0, 0));
    tbl.push_back(mk(0, 1, 7,  0,           E0, 0, 2));
    tbl.push_back(mk(0, 1, 16, 0,           E0, 0, 6));
    tbl.push_back(mk(1, 0, 16, 6,           E1, 6, 0));
    tbl.push_back(mk(0, 1, 16, 0,           E1, 0, 0));
    tbl.push_back(mk(1, 1, 17, 'hFFFFFFFF,  E1, 0, 0));
    tbl.push_back(mk(0, 1, 17, 0,           E1, 0, 0));
    tbl.push_back(mk(1, 0, 16, 1,           E1, 0, 0));
    tbl.push_back(mk(1, 0, 16, 6,           E1, 0, 0));
    tbl.push_back(mk(1, 1, 0,  'h12345678,  E2, 1, 'hDEADBEEF));
    tbl.push_back(mk(1, 0, 3,  3,           E2, 0, 0));
    tbl.push_back(mk(0, 1, 3,  0,           E2, 0, 0));
    tbl.push_back(mk(0, 1, 1,  0,           E2, 0, 0));
    tbl.push_back(mk(0, 1, 5,  0,           E2, 0, 1));
    foreach (tbl[k]) begin
      step(tbl[k].w, tbl[k].r, tbl[k].a, tbl[k].d);
      check($sformatf("vec%0d export", k), cexp, tbl[k].e);
      check($sformatf("vec%0d strobe", k), 128'(stb), 128'(tbl[k].s));
      check($sformatf("vec%0d rvalid", k), 128'(rvalid), 128'(tbl[k].r));
      if (tbl[k].r) check($sformatf("vec%0d rdata", k), 128'(rdata), 128'(tbl[k].er));
    end

    // Pulse of length 5
    step(1'b1, 1'b0, 5'd13, 32'd2);
    step(1'b1, 1'b0, 5'd14, 32'd5);
    step(1'b1, 1'b0, 5'd12, 32'hA5);
    chk3("p5 load", 32'hA5, 1'b1);
    for (int j = 1; j < 5; j++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0);
      chk3($sformatf("p5 hold%0d", j), 32'hA5, 1'b0);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0);
    chk3("p5 end", 32'h0, 1'b0);

    // Zero length gives a single cycle
    step(1'b1, 1'b0, 5'd14, 32'd0);
    step(1'b1, 1'b0, 5'd12, 32'h3C);
    chk3("p0 load", 32'h3C, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    chk3("p0 end", 32'h0, 1'b0);

    // Retrigger at cycle 3 restarts a full 5; PULSE_LEN write mid-pulse leaves the count
    step(1'b1, 1'b0, 5'd14, 32'd5);
    step(1'b1, 1'b0, 5'd12, 32'hA5);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b0, 1'b1, 5'd15, 32'h0);
    check("status active", 128'(rdata), 128'(1));
    step(1'b1, 1'b0, 5'd12, 32'h5A);
    chk3("retrig load", 32'h5A, 1'b1);
    step(1'b1, 1'b0, 5'd14, 32'd1);
    chk3("retrig hold1", 32'h5A, 1'b0);
    for (int j = 2; j < 5; j++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0);
      chk3($sformatf("retrig hold%0d", j), 32'h5A, 1'b0);
    end
    step(1'b0, 1'b0, 5'd0, 32'h0);
    chk3("retrig end", 32'h0, 1'b0);

    // Expiry coinciding with retrigger, then with a MODE write
    step(1'b1, 1'b0, 5'd12, 32'h77);
    step(1'b1, 1'b0, 5'd12, 32'h88);
    chk3("exp+retrig", 32'h88, 1'b1);
    step(1'b1, 1'b0, 5'd13, 32'd2);
    chk3("exp+mode", 32'h0, 1'b0);
    chk_read("exp+mode status", 5'd15, 32'h0);

    // Abort mid-pulse
    step(1'b1, 1'b0, 5'd14, 32'd5);
    step(1'b1, 1'b0, 5'd12, 32'h44);
    step(1'b0, 1'b0, 5'd0, 32'h0);
    step(1'b1, 1'b0, 5'd13, 32'd2);
    chk3("abort", 32'h0, 1'b0);
    chk_read("abort status", 5'd15, 32'h0);
    chk_read("abort shadow kept", 5'd12, 32'h44);

    // Reset mid-pulse with a commit pending, while a strobe is high
    step(1'b1, 1'b0, 5'd4, 32'h33);
    step(1'b1, 1'b0, 5'd12, 32'hBB);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async rst export", cexp, EZ);
    check("async rst strobe", 128'(stb), 128'(0));
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0);
      check("post rst strobe", 128'(stb), 128'(0));
    end
    chk_read("post rst commit", 5'd16, 32'h0);
    chk_read("post rst st3", 5'd15, 32'h0);
    chk_read("post rst plen3", 5'd14, 32'h1);
    chk_read("post rst sh1", 5'd4, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 16));
      if (ra < 5'd16 && ra[1:0] == 2'd1)      rdv = $urandom_range(0, 3);
      else if (ra < 5'd16 && ra[1:0] == 2'd2) rdv = $urandom_range(0, 6);
      else if (ra[1:0] == 2'd0 && ra < 5'd16) rdv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      else                                    rdv = $urandom;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ra, rdv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
